// File: rtl/cdc_cmd_pkg.sv
// Shared definitions for the cdc_cmd responder: protocol byte values,
// FSM state type and the address validity helper.
// Optional feature macro: CDC_CMD_TIMEOUT_EN (inter-byte timeout, see top).
package cdc_cmd_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h3F;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_ADDR = 3'd1,
      GET_DATA = 3'd2,
      EXEC     = 3'd3,
      SEND     = 3'd4
   } state_t;

   // An address is bad when it has bits above the register index range,
   // or when it targets the read-only ID register with a write.
   function automatic logic addr_is_bad(input logic [7:0]  addr,
                                        input logic        is_write,
                                        input int unsigned addr_w);
      return ((addr >> addr_w) != 8'd0) || (is_write && (addr == 8'd0));
   endfunction

endpackage

// File: rtl/cdc_cmd_regfile.sv
// Register file for cdc_cmd_responder: register 0 is a constant ID,
// registers 1..NREGS-1 are writable bytes. Combinational read port and a
// flat view of the whole file.
module cdc_cmd_regfile
   import cdc_cmd_pkg::*;
#(
   parameter int         ADDR_W   = 4,
   parameter logic [7:0] ID_VALUE = 8'hC5
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [7:0]               wr_data,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [7:0]               rd_data,
   output logic [8*(2**ADDR_W)-1:0] regs
);

   localparam int NREGS = 2**ADDR_W;

   logic [7:0] mem_r [1:NREGS-1];

   // Writable registers; index 0 never matches so the ID stays constant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k < NREGS; k++) begin
            mem_r[k] <= 8'd0;
         end
      end else begin
         for (int k = 1; k < NREGS; k++) begin
            if (wr_en && (wr_addr == ADDR_W'(k))) begin
               mem_r[k] <= wr_data;
            end
         end
      end
   end

   // Flat register view with the ID constant in slot 0.
   always_comb begin
      regs       = '0;
      regs[7:0]  = ID_VALUE;
      for (int k = 1; k < NREGS; k++) begin
         regs[8*k +: 8] = mem_r[k];
      end
   end

   // Read mux taken from the flat view so register 0 returns the ID.
   always_comb begin
      rd_data = regs[{rd_addr, 3'b000} +: 8];
   end

endmodule

// File: rtl/cdc_cmd_responder.sv
// Command responder on the usb_cdc application byte stream.
// Parses 'W' addr data / 'R' addr commands, accesses cdc_cmd_regfile and
// returns one response byte per command.
// Optional feature macro: CDC_CMD_TIMEOUT_EN -- when defined, a partially
// received command is silently dropped after TIMEOUT_CYCLES idle cycles.
module cdc_cmd_responder
   import cdc_cmd_pkg::*;
#(
   parameter int         ADDR_W         = 4,
   parameter logic [7:0] ID_VALUE       = 8'hC5,
   parameter int         TIMEOUT_CYCLES = 1_000_000
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               rx_data_i,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   output logic [7:0]               tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic [8*(2**ADDR_W)-1:0] regs_o,
   output logic                     wr_strobe_o,
   output logic [ADDR_W-1:0]        wr_addr_o
);

   state_t             state_r;
   logic               is_write_r;
   logic               op_bad_r;
   logic [7:0]         addr_r;
   logic [7:0]         data_r;
   logic [7:0]         tx_data_r;
   logic               tx_valid_r;
   logic               wr_strobe_r;
   logic [ADDR_W-1:0]  wr_addr_r;

   logic               rx_ready_s;
   logic               rx_fire_s;
   logic               addr_bad_s;
   logic               wr_en_s;
   logic [7:0]         rd_data_s;
   logic               to_hit_s;

   // Accept bytes only while collecting a command and never during reset.
   always_comb begin
      rx_ready_s = 1'b0;
      case (state_r)
         IDLE, GET_ADDR, GET_DATA: rx_ready_s = ~rst_i;
         default:                  rx_ready_s = 1'b0;
      endcase
   end

   // Command decode used in EXEC: validity of the address and the write enable.
   always_comb begin
      rx_fire_s  = rx_valid_i & rx_ready_s;
      addr_bad_s = addr_is_bad(addr_r, is_write_r, ADDR_W);
      if ((state_r == EXEC) && is_write_r && !op_bad_r && !addr_bad_s) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

`ifdef CDC_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt_r;

   // Inter-byte timer: runs only while waiting for the rest of a command.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_cnt_r <= '0;
      end else if (rx_fire_s || ((state_r != GET_ADDR) && (state_r != GET_DATA))) begin
         to_cnt_r <= '0;
      end else begin
         to_cnt_r <= to_cnt_r + TO_W'(1);
      end
   end

   // Timeout reached while still waiting for a byte.
   always_comb begin
      if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
         to_hit_s = 1'b1;
      end else begin
         to_hit_s = 1'b0;
      end
   end
`else
   logic [31:0] timeout_unused_s;

   // Without the timer a partial command waits indefinitely.
   always_comb begin
      to_hit_s         = 1'b0;
      timeout_unused_s = 32'(TIMEOUT_CYCLES);
   end
`endif

   cdc_cmd_regfile #(
      .ADDR_W   (ADDR_W),
      .ID_VALUE (ID_VALUE)
   ) u_regfile (
      .clk     (clk_i),
      .rst     (rst_i),
      .wr_en   (wr_en_s),
      .wr_addr (addr_r[ADDR_W-1:0]),
      .wr_data (data_r),
      .rd_addr (addr_r[ADDR_W-1:0]),
      .rd_data (rd_data_s),
      .regs    (regs_o)
   );

   // Command FSM with registered response and write-strobe outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= IDLE;
         is_write_r  <= 1'b0;
         op_bad_r    <= 1'b0;
         addr_r      <= 8'd0;
         data_r      <= 8'd0;
         tx_data_r   <= 8'd0;
         tx_valid_r  <= 1'b0;
         wr_strobe_r <= 1'b0;
         wr_addr_r   <= '0;
      end else begin
         wr_strobe_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rx_fire_s) begin
                  case (rx_data_i)
                     OP_WRITE: begin
                        is_write_r <= 1'b1;
                        op_bad_r   <= 1'b0;
                        state_r    <= GET_ADDR;
                     end
                     OP_READ: begin
                        is_write_r <= 1'b0;
                        op_bad_r   <= 1'b0;
                        state_r    <= GET_ADDR;
                     end
                     default: begin
                        // Unknown opcode: answer at once, consume nothing more.
                        is_write_r <= 1'b0;
                        op_bad_r   <= 1'b1;
                        state_r    <= EXEC;
                     end
                  endcase
               end
            end
            GET_ADDR: begin
               if (rx_fire_s) begin
                  addr_r  <= rx_data_i;
                  state_r <= is_write_r ? GET_DATA : EXEC;
               end else if (to_hit_s) begin
                  state_r <= IDLE;
               end
            end
            GET_DATA: begin
               if (rx_fire_s) begin
                  data_r  <= rx_data_i;
                  state_r <= EXEC;
               end else if (to_hit_s) begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               tx_valid_r <= 1'b1;
               if (op_bad_r || addr_bad_s) begin
                  tx_data_r <= RSP_ERR;
               end else if (is_write_r) begin
                  tx_data_r   <= RSP_OK;
                  wr_strobe_r <= 1'b1;
                  wr_addr_r   <= addr_r[ADDR_W-1:0];
               end else begin
                  tx_data_r <= rd_data_s;
               end
               state_r <= SEND;
            end
            SEND: begin
               if (tx_ready_i) begin
                  tx_valid_r <= 1'b0;
                  state_r    <= IDLE;
               end
            end
            default: begin
               tx_valid_r <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign rx_ready_o  = rx_ready_s;
   assign tx_data_o   = tx_data_r;
   assign tx_valid_o  = tx_valid_r;
   assign wr_strobe_o = wr_strobe_r;
   assign wr_addr_o   = wr_addr_r;

endmodule

// File: tb/tb_cdc_cmd_responder.sv
// Directed self-checking bench for cdc_cmd_responder (ADDR_W=4, ID 0xC5).
// Covers the timeout path only when CDC_CMD_TIMEOUT_EN is defined.
module tb_cdc_cmd_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   rx_data = 8'd0;
   logic         rx_valid = 1'b0;
   logic         rx_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready = 1'b0;
   logic [127:0] regs;
   logic         wr_strobe;
   logic [3:0]   wr_addr;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   logic [127:0] exp_regs;

   cdc_cmd_responder #(
      .ADDR_W         (4),
      .ID_VALUE       (8'hC5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .rx_ready_o  (rx_ready),
      .tx_data_o   (tx_data),
      .tx_valid_o  (tx_valid),
      .tx_ready_i  (tx_ready),
      .regs_o      (regs),
      .wr_strobe_o (wr_strobe),
      .wr_addr_o   (wr_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and wait (bounded) until it is accepted.
   task automatic send_byte(input logic [7:0] b);
      logic done;
      done     = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!done) begin
            if (rx_ready) begin
               done = 1'b1;
            end
            tick();
         end
      end
      rx_valid = 1'b0;
      chk("rx_accept", {127'd0, done}, 128'd1);
   endtask

   // Send n bytes, check N+1 / N+2 timing, response, write effects, handshake.
   task automatic run_cmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] rsp,
                          input logic exp_wr, input logic [3:0] exp_wa,
                          input logic [127:0] regs_after);
      send_byte(b0);
      if (n > 1) send_byte(b1);
      if (n > 2) send_byte(b2);
      chk("tx_valid_n1", {127'd0, tx_valid}, 128'd0);
      chk("regs_n1", regs, exp_regs);
      tick();
      chk("tx_valid_n2", {127'd0, tx_valid}, 128'd1);
      chk("tx_data", {120'd0, tx_data}, {120'd0, rsp});
      chk("wr_strobe_n2", {127'd0, wr_strobe}, {127'd0, exp_wr});
      chk("wr_addr", {124'd0, wr_addr}, {124'd0, exp_wa});
      chk("regs_n2", regs, regs_after);
      chk("rx_ready_send", {127'd0, rx_ready}, 128'd0);
      exp_regs = regs_after;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("tx_valid_done", {127'd0, tx_valid}, 128'd0);
      chk("wr_strobe_done", {127'd0, wr_strobe}, 128'd0);
      chk("rx_ready_idle", {127'd0, rx_ready}, 128'd1);
   endtask

   initial begin
      logic [127:0] nxt;
      exp_regs = {120'd0, 8'hC5};

      // Reset state
      tick();
      chk("rst_rx_ready", {127'd0, rx_ready}, 128'd0);
      chk("rst_tx_valid", {127'd0, tx_valid}, 128'd0);
      chk("rst_tx_data", {120'd0, tx_data}, 128'd0);
      chk("rst_wr_strobe", {127'd0, wr_strobe}, 128'd0);
      chk("rst_wr_addr", {124'd0, wr_addr}, 128'd0);
      chk("rst_regs", regs, exp_regs);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_rx_ready", {127'd0, rx_ready}, 128'd1);

      // Read ID register
      run_cmd(2, 8'h52, 8'h00, 8'h00, 8'hC5, 1'b0, 4'd0, exp_regs);

      // Write register 3, then read it back
      nxt = exp_regs; nxt[31:24] = 8'hA5;
      run_cmd(3, 8'h57, 8'h03, 8'hA5, 8'h4B, 1'b1, 4'd3, nxt);
      run_cmd(2, 8'h52, 8'h03, 8'h00, 8'hA5, 1'b0, 4'd3, exp_regs);

      // Bad addresses: out of range, and write to the ID register
      run_cmd(3, 8'h57, 8'h10, 8'h11, 8'h3F, 1'b0, 4'd3, exp_regs);
      run_cmd(3, 8'h57, 8'h00, 8'h11, 8'h3F, 1'b0, 4'd3, exp_regs);
      run_cmd(2, 8'h52, 8'h00, 8'h00, 8'hC5, 1'b0, 4'd3, exp_regs);
      run_cmd(2, 8'h52, 8'h20, 8'h00, 8'h3F, 1'b0, 4'd3, exp_regs);

      // Unknown opcode, then resync with tx_ready already high
      run_cmd(1, 8'h41, 8'h00, 8'h00, 8'h3F, 1'b0, 4'd3, exp_regs);
      tx_ready = 1'b1;
      run_cmd(2, 8'h52, 8'h01, 8'h00, 8'h00, 1'b0, 4'd3, exp_regs);

      // Stalled response with a pending rx byte
      send_byte(8'h57);
      send_byte(8'h02);
      send_byte(8'h5A);
      tick();
      exp_regs[23:16] = 8'h5A;
      chk("stall_regs", regs, exp_regs);
      chk("stall_strobe", {127'd0, wr_strobe}, 128'd1);
      rx_data  = 8'h52;
      rx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("stall_tx_valid", {127'd0, tx_valid}, 128'd1);
         chk("stall_tx_data", {120'd0, tx_data}, {120'd0, 8'h4B});
         chk("stall_rx_ready", {127'd0, rx_ready}, 128'd0);
         tick();
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("stall_release", {127'd0, tx_valid}, 128'd0);
      chk("stall_idle_ready", {127'd0, rx_ready}, 128'd1);
      tick();
      rx_valid = 1'b0;
      run_cmd(1, 8'h02, 8'h00, 8'h00, 8'h5A, 1'b0, 4'd2, exp_regs);

      // Reset in the middle of a write
      send_byte(8'h57);
      send_byte(8'h05);
      rst = 1'b1;
      #1;
      chk("midrst_rx_ready", {127'd0, rx_ready}, 128'd0);
      exp_regs = {120'd0, 8'hC5};
      chk("midrst_regs", regs, exp_regs);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("midrst_no_rsp", {127'd0, tx_valid}, 128'd0);
         chk("midrst_no_wr", {127'd0, wr_strobe}, 128'd0);
         tick();
      end
      chk("midrst_wr_addr", {124'd0, wr_addr}, 128'd0);
      run_cmd(2, 8'h52, 8'h05, 8'h00, 8'h00, 1'b0, 4'd0, exp_regs);
      run_cmd(2, 8'h52, 8'h03, 8'h00, 8'h00, 1'b0, 4'd0, exp_regs);

`ifdef CDC_CMD_TIMEOUT_EN
      // Partial command abandoned by the inter-byte timer
      send_byte(8'h57);
      for (int i = 0; i < 20; i++) begin
         chk("to_no_rsp", {127'd0, tx_valid}, 128'd0);
         tick();
      end
      chk("to_idle_ready", {127'd0, rx_ready}, 128'd1);
      run_cmd(2, 8'h52, 8'h00, 8'h00, 8'hC5, 1'b0, 4'd0, exp_regs);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
